// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift register.
// Provides the 3-bit mode encodings, the burst FSM state type and a helper
// that tells whether a mode can be launched as a multi-step burst.
package shreg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_ASR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Only the shift/rotate family is meaningful when repeated.
    function automatic logic is_burst_mode(input logic [2:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
               (m == MODE_ROR) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/shreg_step.sv
// One-step next-value logic for the universal register (purely combinational).
// Ports:
//   q      - current register contents
//   mode   - operation select (shreg_pkg MODE_* encodings)
//   d      - parallel load data
//   sin_l  - serial bit entering at the MSB on right shifts
//   sin_r  - serial bit entering at the LSB on left shifts
//   q_next - value the register takes if this step is applied
module shreg_step
    import shreg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        unique case (mode)
            MODE_HOLD: q_next = q;
            MODE_LOAD: q_next = d;
            MODE_SHL:  q_next = {q[WIDTH-2:0], sin_r};
            MODE_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            MODE_CLR:  q_next = '0;
            MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/param_shift_register.sv
// Parametrised universal register with single-cycle ops and a counted burst
// mode (shift/rotate by shamt places, one place per clock).
// Ports:
//   clk, rst_n     - rising-edge clock, asynchronous active-low reset
//   mode           - operation select (shreg_pkg MODE_* encodings)
//   d              - parallel load data
//   sin_l, sin_r   - serial inputs at the MSB / LSB ends
//   start, shamt   - launch a burst of 'mode' for 'shamt' steps (0..WIDTH)
//   q              - register contents
//   sout_l, sout_r - q MSB / LSB
//   busy, done     - burst in progress / one-cycle completion pulse
module param_shift_register
    import shreg_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    input  logic [CW-1:0]    shamt,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CW-1:0]    shamt_sat;
    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_q;
    logic             launch;

    // Out-of-range step counts clamp to a full-width burst.
    assign shamt_sat = (shamt > CW'(WIDTH)) ? CW'(WIDTH) : shamt;
    assign launch    = start && is_burst_mode(mode);
    assign step_mode = (state_q == ST_RUN) ? mode_q : mode;

    shreg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q      (q_q),
        .mode   (step_mode),
        .d      (d),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .q_next (step_q)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    mode_d  = mode;
                    cnt_d   = shamt_sat;
                    state_d = (shamt_sat == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered handshake outputs
    always_comb begin
        q_d = q_q;
        unique case (state_q)
            ST_IDLE: q_d = launch ? q_q : step_q;
            ST_RUN:  q_d = step_q;
            ST_FIN:  q_d = q_q;
            default: q_d = q_q;
        endcase
        // busy covers RUN and the trailing FIN cycle; done marks the FIN->IDLE edge.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_FIN);
    end

    assign q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
